// File: rtl/cmp_branch_ctrl_pkg.sv
// Shared opcode and state encodings for the comparator/branch sequencer.
package cmp_branch_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_CMP  = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BLT  = 3'd3,
    OP_BGE  = 3'd4,
    OP_BGT  = 3'd5,
    OP_BLE  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/cmp_branch_ctrl_cond_eval.sv
// Branch condition decode from the stored zero/less-than flags; shared with
// any future predicated-execution logic.
module cmp_cond_eval
  import cmp_branch_ctrl_pkg::*;
(
  input  logic [2:0] op,
  input  logic       z,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = !z;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = !lt;
      OP_BGT:  taken = !lt && !z;
      OP_BLE:  taken = lt || z;
      default: taken = 1'b0;  // CMP and the reserved code never branch
    endcase
  end

endmodule

// File: rtl/cmp_branch_ctrl.sv
// Comparator register and conditional-branch sequencer: IDLE -> EXEC ->
// (REDIRECT) -> DONE, with a registered PC redirect to fetch.
module cmp_branch_ctrl
  import cmp_branch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] rs_a,
  input  logic [WIDTH-1:0] rs_b,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  offset,
  output logic [WIDTH-1:0] cmp_q,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             done,
  output logic             busy,
  output state_e           dbg_state
);

  // Handshakes: a request is accepted on a rising edge where req_valid and
  // req_ready are both high; a redirect retires on an edge where
  // redirect_valid and redirect_ready are both high. Valid-side payloads
  // stay stable until the matching ready is seen.

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PC_W-1:0]  pc_q, pc_d, off_q, off_d;
  logic [WIDTH-1:0] cmp_d;
  logic             z_q, z_d, lt_q, lt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             done_q, done_d;
  logic             taken;
  logic [WIDTH:0]   diff;

  // One extra sign bit keeps the signed less-than correct across overflow.
  assign diff = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};

  cmp_cond_eval u_cond (
    .op    (op_q),
    .z     (z_q),
    .lt    (lt_q),
    .taken (taken)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    pc_d          = pc_q;
    off_d         = off_q;
    cmp_d         = cmp_q;
    z_d           = z_q;
    lt_d          = lt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = rs_a;
          b_d     = rs_b;
          pc_d    = pc;
          off_d   = offset;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_CMP) begin
          cmp_d   = diff[WIDTH-1:0];
          z_d     = (a_q == b_q);
          lt_d    = diff[WIDTH];
          state_d = ST_DONE;
        end else if (taken) begin
          redirect_pc_d = pc_q + off_q;
          state_d       = ST_REDIRECT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    redirect_valid_d = (state_d == ST_REDIRECT);
    done_d           = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      op_q             <= '0;
      a_q              <= '0;
      b_q              <= '0;
      pc_q             <= '0;
      off_q            <= '0;
      cmp_q            <= '0;
      z_q              <= 1'b1;
      lt_q             <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      a_q              <= a_d;
      b_q              <= b_d;
      pc_q             <= pc_d;
      off_q            <= off_d;
      cmp_q            <= cmp_d;
      z_q              <= z_d;
      lt_q             <= lt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      done_q           <= done_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign done           = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cmp_branch_ctrl.sv
// Bench for cmp_branch_ctrl: directed vector table, reset corner sequences,
// then random requests checked against a flag-level reference model.
module tb_cmp_branch_ctrl;
  import cmp_branch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] rs_a, rs_b, pc, offset;
  logic [31:0] cmp_q;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        done;
  logic        busy;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the comparator value and its two flags.
  logic [31:0] mdl_cmp = 32'd0;
  bit          mdl_z   = 1'b1;
  bit          mdl_lt  = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] o;
    int          stall;
    bit          poke;
    bit          taken;
    logic [31:0] exp_pc;
    logic [31:0] exp_cmp;
  } vec_t;

  vec_t tbl[17];

  cmp_branch_ctrl #(.WIDTH(32), .PC_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .rs_a           (rs_a),
    .rs_b           (rs_b),
    .pc             (pc),
    .offset         (offset),
    .cmp_q          (cmp_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .done           (done),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (failures so far %0d)", n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mdl_taken(input logic [2:0] op);
    case (op)
      3'd1:    return mdl_z;
      3'd2:    return !mdl_z;
      3'd3:    return mdl_lt;
      3'd4:    return !mdl_lt;
      3'd5:    return !mdl_lt && !mdl_z;
      3'd6:    return mdl_lt || mdl_z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void mdl_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0) begin
      mdl_cmp = a - b;
      mdl_z   = (a == b);
      mdl_lt  = ($signed(a) < $signed(b));
    end
  endfunction

  function automatic void mdl_reset();
    mdl_cmp = 32'd0;
    mdl_z   = 1'b1;
    mdl_lt  = 1'b0;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    check("ready_before_req", req_ready, 1);
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] o, input int stall,
                        input bit poke, input bit exp_taken, input logic [31:0] exp_pc,
                        input logic [31:0] exp_cmp);
    wait_ready();
    req_valid      = 1'b1;
    req_op         = op;
    rs_a           = a;
    rs_b           = b;
    pc             = p;
    offset         = o;
    redirect_ready = (stall == 0);
    step();
    req_valid = 1'b0;
    rs_a      = $urandom;
    rs_b      = $urandom;
    pc        = $urandom;
    offset    = $urandom;
    check("exec_busy", busy, 1);
    check("exec_req_ready", req_ready, 0);
    check("exec_state", dbg_state, ST_EXEC);
    if (exp_taken) begin
      step();
      check("redir_valid", redirect_valid, 1);
      check("redir_pc", redirect_pc, exp_pc);
      check("redir_no_done", done, 0);
      for (int i = 0; i < stall; i++) begin
        if (poke) begin
          req_valid = 1'b1;
          req_op    = 3'd0;
          rs_a      = 32'd1;
          rs_b      = 32'd0;
        end
        step();
        check("stall_valid", redirect_valid, 1);
        check("stall_pc", redirect_pc, exp_pc);
        check("stall_req_ready", req_ready, 0);
        check("stall_no_done", done, 0);
      end
      req_valid      = 1'b0;
      redirect_ready = 1'b1;
      step();
      check("redir_done", done, 1);
      check("redir_valid_drop", redirect_valid, 0);
      redirect_ready = 1'b0;
    end else begin
      step();
      check("done_pulse", done, 1);
      check("no_redirect", redirect_valid, 0);
    end
    check("cmp_q", cmp_q, exp_cmp);
    step();
    check("done_low", done, 0);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, p, o;
    bit          tk;

    reset          = 1'b1;
    req_valid      = 1'b0;
    req_op         = 3'd0;
    rs_a           = 32'd0;
    rs_b           = 32'd0;
    pc             = 32'd0;
    offset         = 32'd0;
    redirect_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cmp_q", cmp_q, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Directed vectors, expectations worked out by hand from reset state.
    tbl[0]  = '{3'd0, 32'd73,        32'd17,        32'h0,        32'h0,        0, 0, 0, 32'h0,        32'd56};
    tbl[1]  = '{3'd5, 32'h0,         32'h0,         32'h100,      32'h20,       0, 0, 1, 32'h120,      32'd56};
    tbl[2]  = '{3'd6, 32'h0,         32'h0,         32'h100,      32'h20,       0, 0, 0, 32'h0,        32'd56};
    tbl[3]  = '{3'd0, 32'h80000000,  32'h1,         32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h7FFFFFFF};
    tbl[4]  = '{3'd3, 32'h0,         32'h0,         32'hFFFFFFF0, 32'h20,       0, 0, 1, 32'h10,       32'h7FFFFFFF};
    tbl[5]  = '{3'd4, 32'h0,         32'h0,         32'h40,       32'h4,        0, 0, 0, 32'h0,        32'h7FFFFFFF};
    tbl[6]  = '{3'd0, 32'd5,         32'd5,         32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0};
    tbl[7]  = '{3'd1, 32'h0,         32'h0,         32'h200,      32'hFFFFFFFC, 3, 1, 1, 32'h1FC,      32'h0};
    tbl[8]  = '{3'd7, 32'h0,         32'h0,         32'h300,      32'h8,        0, 0, 0, 32'h0,        32'h0};
    tbl[9]  = '{3'd2, 32'h0,         32'h0,         32'h300,      32'h8,        0, 0, 0, 32'h0,        32'h0};
    tbl[10] = '{3'd0, 32'd1,         32'd2,         32'h0,        32'h0,        0, 0, 0, 32'h0,        32'hFFFFFFFF};
    tbl[11] = '{3'd6, 32'h0,         32'h0,         32'h0,        32'h4,        1, 0, 1, 32'h4,        32'hFFFFFFFF};
    tbl[12] = '{3'd5, 32'h0,         32'h0,         32'h0,        32'h4,        0, 0, 0, 32'h0,        32'hFFFFFFFF};
    tbl[13] = '{3'd0, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h80000000};
    tbl[14] = '{3'd5, 32'h0,         32'h0,         32'h1000,     32'h10,       2, 0, 1, 32'h1010,     32'h80000000};
    tbl[15] = '{3'd3, 32'h0,         32'h0,         32'h1000,     32'h10,       0, 0, 0, 32'h0,        32'h80000000};
    tbl[16] = '{3'd2, 32'h0,         32'h0,         32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h80000000};

    for (int i = 0; i < 17; i++) begin
      do_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].o, tbl[i].stall,
             tbl[i].poke, tbl[i].taken, tbl[i].exp_pc, tbl[i].exp_cmp);
      mdl_apply(tbl[i].op, tbl[i].a, tbl[i].b);
    end

    // Reset while a redirect is stalled: everything clears without a clock edge.
    do_req(3'd0, 32'd9, 32'd3, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'd6);
    mdl_apply(3'd0, 32'd9, 32'd3);
    wait_ready();
    req_valid = 1'b1; req_op = 3'd2; pc = 32'h300; offset = 32'h10; redirect_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    check("pre_rst_redirect_valid", redirect_valid, 1);
    check("pre_rst_redirect_pc", redirect_pc, 32'h310);
    #2 reset = 1'b1;
    #1;
    check("async_rst_redirect_valid", redirect_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_cmp_q", cmp_q, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_rst_no_done", done, 0);
    end
    do_req(3'd1, 32'h0, 32'h0, 32'h80, 32'h40, 0, 0, mdl_taken(3'd1), 32'hC0, 32'h0);

    // Reset while a CMP sits in EXEC: cmp_q must not take the new difference.
    wait_ready();
    req_valid = 1'b1; req_op = 3'd0; rs_a = 32'd100; rs_b = 32'd1;
    step();
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("exec_rst_cmp_q", cmp_q, 0);
    check("exec_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("exec_rst_no_done", done, 0);
    do_req(3'd2, 32'h0, 32'h0, 32'h10, 32'h10, 0, 0, 0, 32'h0, 32'h0);

    // Random requests against the model.
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = 3'd0;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = $urandom;
      endcase
      p  = $urandom;
      o  = $urandom;
      tk = mdl_taken(op);
      mdl_apply(op, a, b);
      do_req(op, a, b, p, o, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             tk, p + o, mdl_cmp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_branch_ctrl.md
# cmp_branch_ctrl

Sequencer for the processor's comparator register and conditional branching. It accepts compare and branch requests from the control unit. A compare loads the comparator register with the 32-bit difference of two register operands. A branch evaluates a condition against the stored result and, when taken, issues a PC redirect to fetch over a valid/ready handshake. It sits between the control unit, the register-file read ports and the fetch/PC logic.

## Interface
- WIDTH, 32, operand and comparator width
- PC_W, 32, program-counter width

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  3  0 CMP, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BGT, 6 BLE, 7 reserved (never taken)
- rs_a, rs_b  in  WIDTH  operand values, used by CMP only
- pc  in  PC_W  PC of the branch instruction
- offset  in  PC_W  sign-extended branch offset
- cmp_q  out  WIDTH  comparator register (a − b)
- redirect_valid  out  1  redirect target is valid
- redirect_pc  out  PC_W  branch target
- redirect_ready  in  1  fetch accepts the redirect
- done  out  1  one-cycle retire pulse
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, REDIRECT, DONE.
- IDLE: on req_valid & req_ready, capture req_op, rs_a, rs_b, pc and offset. Go to EXEC.
- EXEC with CMP:
  - cmp_q ← (rs_a − rs_b) mod 2^WIDTH.
  - z ← (rs_a == rs_b).
  - lt ← signed rs_a < rs_b, computed from a 33-bit sign-extended subtraction so overflow is handled correctly.
  - Go to DONE.
- EXEC with a branch: evaluate the condition from the stored z/lt flags. The operands are ignored.
  - BEQ z; BNE !z; BLT lt; BGE !lt; BGT !lt & !z; BLE lt | z; op 7 → 0.
  - Taken: redirect_pc ← pc + offset (wraps mod 2^PC_W). Go to REDIRECT.
  - Not taken: go to DONE.
- REDIRECT: hold redirect_valid and redirect_pc stable until redirect_ready is sampled high. Then go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- A branch never modifies cmp_q or the flags.
- req_valid outside IDLE is ignored; the requester must hold it.

## Timing
- Reset values:
  - state IDLE, req_ready 1, busy 0, done 0.
  - cmp_q 0, z 1, lt 0.
  - redirect_valid 0, redirect_pc 0.
- CMP accepted at edge N:
  - cmp_q updates at edge N+1.
  - done is high in cycle N+1.
  - req_ready returns high after edge N+2.
- Not-taken branch: same latency as CMP.
- Taken branch accepted at edge N:
  - redirect_valid is high from edge N+1.
  - If redirect_ready is already high, the handshake completes at edge N+2, done is high in cycle N+2, and the unit is idle after edge N+3.
  - Each stalled cycle of redirect_ready adds one cycle.
- Minimum spacing between accepted requests is 3 cycles (4 for a taken branch).
- Reset asserted mid-operation clears all state immediately and asynchronously.
  - An in-flight redirect_valid drops with no done pulse.
  - A CMP in EXEC does not update cmp_q.
- All outputs are registered except req_ready and busy, which are decoded from the state.

## Structure
- Shared include cmp_branch_defs.vh holds:
  - opcode constants CMP…BLE and the reserved code 7;
  - state encodings IDLE/EXEC/REDIRECT/DONE.
- One combinational sub-module, cmp_cond_eval: inputs op, z, lt; output taken. It is reused by any future predicated-execution logic.
- FSM, flag registers and redirect register stay in cmp_branch_ctrl.

## Test plan
- CMP rs_a=73 (0x49), rs_b=17 (0x11) → cmp_q=56, z=0, lt=0; done pulses 1 cycle after accept.
- After the CMP above, BGT pc=0x100, offset=0x20 with redirect_ready=1 → redirect_valid for 1 cycle, redirect_pc=0x120, then done. BLE under the same conditions → no redirect, done at N+1.
- CMP rs_a=0x80000000, rs_b=1 → cmp_q=0x7FFFFFFF, lt=1. Then BLT pc=0xFFFFFFF0, offset=0x20 → redirect_pc=0x00000010 (wrap).
- Taken BEQ after CMP 5,5 with redirect_ready held low 3 cycles → redirect_pc stable throughout, done exactly 1 cycle after ready. A second req_valid during the stall is not accepted (req_ready=0).
- Reset asserted while in REDIRECT → redirect_valid=0, busy=0, cmp_q=0 with no clock edge needed; no done pulse. A following BEQ is taken (z=1 after reset).
- Op 7 and BNE after CMP 5,5 → no redirect; cmp_q unchanged at 0.
